// File: rtl/rr_merge_pkg.sv
// Shared helpers for the round-robin merge: index wrap and merged-word field layout.
package rr_merge_pkg;

  // Merged word: payload in the low bits, source index directly above it.
  localparam int unsigned PAYLOAD_LSB = 0;

  function automatic int unsigned idx_lsb(input int unsigned w_data);
    return PAYLOAD_LSB + w_data;
  endfunction

  // Explicit wrap so non-power-of-two sizes never produce an index >= size.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned size);
    return (idx + 1 >= size) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning from ptr, ptr advances past the winner.
module rr_arbiter
  import rr_merge_pkg::*;
#(
  parameter int SIZE  = 2,
  parameter int W_IDX = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SIZE-1:0]  req,
  input  logic             advance,
  output logic [SIZE-1:0]  grant,
  output logic [W_IDX-1:0] grant_idx
);

  logic [W_IDX-1:0] ptr_q, ptr_d;
  logic [W_IDX-1:0] scan;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    scan      = ptr_q;
    for (int k = 0; k < SIZE; k++) begin
      if (!found && req[scan]) begin
        found       = 1'b1;
        grant[scan] = 1'b1;
        grant_idx   = scan;
      end
      scan = W_IDX'(next_idx(32'(scan), unsigned'(SIZE)));
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = W_IDX'(next_idx(32'(grant_idx), unsigned'(SIZE)));
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rr_merge.sv
// Round-robin merge of SIZE valid/ready inputs onto one registered output tagged
// with the source index; one cycle latency, full throughput.
module rr_merge
  import rr_merge_pkg::*;
#(
  parameter int SIZE   = 2,
  parameter int W_DATA = 16,
  parameter int W_IDX  = $clog2(SIZE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SIZE-1:0]          din_valid,
  output logic [SIZE-1:0]          din_ready,
  input  logic [SIZE*W_DATA-1:0]   din_data,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [W_IDX+W_DATA-1:0]  dout_data
);

  logic [SIZE-1:0]          grant;
  logic [W_IDX-1:0]         grant_idx;
  logic                     load;
  logic                     advance;
  logic [W_DATA-1:0]        din_arr [SIZE];
  logic                     dout_valid_q, dout_valid_d;
  logic [W_IDX+W_DATA-1:0]  dout_data_q, dout_data_d;

  for (genvar i = 0; i < SIZE; i++) begin : g_unpack
    assign din_arr[i] = din_data[i*W_DATA +: W_DATA];
  end

  // Drain and refill in the same cycle: the register is free when empty or being taken.
  assign load      = !dout_valid_q | dout_ready;
  assign advance   = load & !rst & (|din_valid);
  assign din_ready = (load & !rst) ? grant : '0;

  rr_arbiter #(
    .SIZE  (SIZE),
    .W_IDX (W_IDX)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (din_valid),
    .advance   (advance),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    dout_valid_d = dout_valid_q;
    dout_data_d  = dout_data_q;
    if (load) begin
      dout_valid_d = advance;
      if (advance) begin
        dout_data_d[PAYLOAD_LSB +: W_DATA]   = din_arr[grant_idx];
        dout_data_d[idx_lsb(W_DATA) +: W_IDX] = grant_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
    end else begin
      dout_valid_q <= dout_valid_d;
      dout_data_q  <= dout_data_d;
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout_data  = dout_data_q;

endmodule

// File: tb/tb_rr_merge.sv
// Bench for rr_merge: SIZE=3 and SIZE=5 instances checked every cycle against a
// queue-based reference model under directed and random traffic.
module tb_rr_merge;

  logic        clk = 1'b0;
  logic [1:0]  rst_c;
  logic [1:0]  ordy;

  logic [2:0]  v3, r3;
  logic [47:0] dat3;
  logic        dv3;
  logic [17:0] do3;

  logic [4:0]  v5, r5;
  logic [79:0] dat5;
  logic        dv5;
  logic [18:0] do5;

  always #5 clk = ~clk;

  rr_merge #(.SIZE(3), .W_DATA(16)) u3 (
    .clk(clk), .rst(rst_c[0]), .din_valid(v3), .din_ready(r3), .din_data(dat3),
    .dout_valid(dv3), .dout_ready(ordy[0]), .dout_data(do3)
  );

  rr_merge #(.SIZE(5), .W_DATA(16)) u5 (
    .clk(clk), .rst(rst_c[1]), .din_valid(v5), .din_ready(r5), .din_data(dat5),
    .dout_valid(dv5), .dout_ready(ordy[1]), .dout_data(do5)
  );

  // Reference model state
  int          sz [2] = '{3, 5};
  int          ptr [2];
  bit          mv [2];
  logic [31:0] md [2];
  bit          vd [2][5];
  bit          took [2][5];
  logic [15:0] q [2][5][$];
  int          g_now [2];
  bit          load_now [2];
  bit          gaps;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [31:0] er;
    // Producers: hold valid until taken, otherwise offer the next queued word.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < sz[d]; i++) begin
        if (!(vd[d][i] && !took[d][i]))
          vd[d][i] = (q[d][i].size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
        took[d][i] = 1'b0;
      end
    for (int i = 0; i < 3; i++) begin
      v3[i] = vd[0][i];
      dat3[i*16 +: 16] = (q[0][i].size() > 0) ? q[0][i][0] : 16'h0;
    end
    for (int i = 0; i < 5; i++) begin
      v5[i] = vd[1][i];
      dat5[i*16 +: 16] = (q[1][i].size() > 0) ? q[1][i][0] : 16'h0;
    end

    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      g_now[d]    = -1;
      load_now[d] = !rst_c[d] && (!mv[d] || ordy[d]);
      if (load_now[d])
        for (int k = 0; k < sz[d]; k++) begin
          int i;
          i = (ptr[d] + k) % sz[d];
          if (g_now[d] < 0 && vd[d][i]) g_now[d] = i;
        end
      er = '0;
      if (g_now[d] >= 0) er[g_now[d]] = 1'b1;
      chk($sformatf("s%0d din_ready", sz[d]), (d == 0) ? 32'(r3) : 32'(r5), er);
      chk($sformatf("s%0d dout_valid", sz[d]), (d == 0) ? 32'(dv3) : 32'(dv5), 32'(mv[d]));
      if (mv[d])
        chk($sformatf("s%0d dout_data", sz[d]), (d == 0) ? 32'(do3) : 32'(do5), md[d]);
    end

    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst_c[d]) begin
        mv[d] = 1'b0; md[d] = '0; ptr[d] = 0;
      end else if (load_now[d]) begin
        if (g_now[d] >= 0) begin
          mv[d] = 1'b1;
          md[d] = (32'(g_now[d]) << 16) | 32'(q[d][g_now[d]][0]);
          ptr[d] = (g_now[d] + 1) % sz[d];
          took[d][g_now[d]] = 1'b1;
          void'(q[d][g_now[d]].pop_front());
        end else begin
          mv[d] = 1'b0;
        end
      end
    end
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    gaps = 1'b0;
    for (int d = 0; d < 2; d++) begin
      ptr[d] = 0; mv[d] = 1'b0; md[d] = '0;
      for (int i = 0; i < 5; i++) begin vd[d][i] = 1'b0; took[d][i] = 1'b0; end
    end
    rst_c = 2'b11; ordy = 2'b11;
    v3 = '0; dat3 = '0; v5 = '0; dat5 = '0;
    @(posedge clk); #1;

    // Reset and idle
    ticks(3);
    rst_c = 2'b00;
    ticks(3);

    // Single input on SIZE=3
    q[0][1].push_back(16'h11); q[0][1].push_back(16'h22); q[0][1].push_back(16'h33);
    ticks(5);

    // Full contention on SIZE=3
    for (int n = 0; n < 6; n++)
      for (int i = 0; i < 3; i++) q[0][i].push_back(16'(16'hA0 + i));
    ticks(21);

    // Back-pressure with inputs 0 and 2 pending
    for (int n = 0; n < 3; n++) begin
      q[0][0].push_back(16'(16'hB0 + n));
      q[0][2].push_back(16'(16'hC0 + n));
    end
    tick();
    ordy[0] = 1'b0;
    ticks(4);
    ordy[0] = 1'b1;
    ticks(8);

    // Wrap-around on SIZE=5
    q[1][4].push_back(16'h0404);
    ticks(3);
    q[1][0].push_back(16'h0100);
    q[1][4].push_back(16'h0444);
    ticks(4);

    // Mid-stream reset while the output is stalled
    for (int i = 0; i < 3; i++) begin
      q[0][i].push_back(16'(16'hD0 + i));
      q[0][i].push_back(16'(16'hE0 + i));
    end
    ordy[0] = 1'b0;
    ticks(2);
    rst_c[0] = 1'b1;
    tick();
    rst_c[0] = 1'b0;
    ordy[0] = 1'b1;
    ticks(8);

    // Randomized traffic on both instances
    gaps = 1'b1;
    for (int c = 0; c < 600; c++) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < sz[d]; i++)
          if ($urandom_range(0, 2) == 0 && q[d][i].size() < 4)
            q[d][i].push_back(16'($urandom));
        ordy[d]  = ($urandom_range(0, 3) != 0);
        rst_c[d] = ($urandom_range(0, 149) == 0);
      end
      tick();
    end
    rst_c = 2'b00; ordy = 2'b11; gaps = 1'b0;
    ticks(30);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/rr_merge.md
# rr_merge

Round-robin merge stage that rejoins the SIZE parallel dti branches fanned out by the broadcast stage, or any set of independent producers, onto a single dti producer. Each transfer is tagged with the index of the input it came from. The output is registered: the block gives one cycle of latency and sustains full throughput. Arbitration is fair. Only the granted input sees ready.

## Interface
- SIZE, 2: number of dti consumer inputs, ≥2
- W_DATA, 16: data width of each input
- W_IDX, $clog2(SIZE): width of the index tag
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high; clock clk
- din[SIZE-1:0]  dti.consumer  W_DATA  input channels
- dout  dti.producer  W_IDX+W_DATA  merged channel; data[W_DATA-1:0] = payload, data[W_IDX+W_DATA-1:W_DATA] = source index

## Operation
- dti rules apply on all ports: a transfer occurs on a cycle where valid & ready are both high. A producer holds valid and data stable until the transfer.
- load = !dout.valid | dout.ready. The output register may accept a new word this cycle.
- Round-robin pointer ptr, W_IDX bits, range 0..SIZE-1.
- Request vector: req[i] = din[i].valid.
- Grant: one-hot. Scan order is ptr, ptr+1, …, SIZE-1, 0, …, ptr-1. The first index with req set wins. If req is all zero, no grant.
- din[i].ready = load & grant[i]. Ready is high for at most one input per cycle. Ready may depend combinationally on the input valids and on dout.ready.
- On a transfer from input g:
  - the output register loads {g, din[g].data};
  - dout.valid <= 1;
  - ptr <= (g+1) mod SIZE. Wrap-around is explicit, including for non-power-of-two SIZE.
- If load=1 and no input transfers, dout.valid <= 0 and ptr is unchanged.
- If load=0 (output stalled): output register, dout.valid and ptr all hold, and every din.ready is 0.
- dout.data is driven only from the register. There is no combinational path from din.data to dout.

## Timing
- Reset values: dout.valid=0, ptr=0, output data register=0. During rst every din.ready=0.
- Latency: input transfer in cycle n → dout.valid with that word in cycle n+1.
- Throughput:
  - One word per cycle when dout.ready is held high and any input is valid.
  - With all SIZE inputs continuously valid, the sources appear in strict rotation: ptr, ptr+1, … mod SIZE.
- Back-pressure: dout.valid=1 & dout.ready=0 → all din.ready=0 in the same cycle. The register contents stay stable.
- Output drain and refill happen in the same cycle. dout.ready=1 with a pending request → the next word is loaded, so there are no bubbles.
- Single active input: served every cycle, and ptr tracks g+1.
- Reset asserted mid-stream: the word held in the output register is discarded. Any input handshake pending in that cycle does not occur (ready=0).
- Index for non-power-of-two SIZE: W_IDX covers the range, and indices ≥ SIZE never appear.

## Structure
- Shared package rr_merge_pkg:
  - function next_idx(idx, size), giving (idx+1) mod size;
  - the output field layout (payload LSBs, index MSBs) as typedef-helper localparams.
- One sub-module: rr_arbiter.
  - Parameter SIZE.
  - Inputs: clk, rst, req[SIZE], advance.
  - Outputs: grant[SIZE] (one-hot), grant_idx[W_IDX].
  - It owns ptr and updates it when advance=1.
- rr_merge holds the output register, the load logic, the ready gating and the payload mux.
- Target size: about 150–250 lines of RTL in total.

## Test plan
- Reset and idle:
  - Stimulus: rst for 3 cycles, then all din.valid=0.
  - Response: dout.valid=0 and all din.ready=0 throughout reset; dout.valid stays 0 after reset.
- Single input, SIZE=3:
  - Stimulus: din[1] sends 0x11, 0x22, 0x33 back-to-back; dout.ready=1.
  - Response: dout data {1,0x11}, {1,0x22}, {1,0x33} on consecutive cycles, each one cycle after its input transfer.
- Full contention, SIZE=3:
  - Stimulus: all inputs continuously valid with data 0xA0+i; dout.ready=1.
  - Response: index sequence 0,1,2,0,1,2… with no bubble cycles.
- Back-pressure:
  - Stimulus: dout.ready=0 for 4 cycles while din[0] and din[2] are valid.
  - Response: dout holds its first word; all din.ready=0; no input data is lost; after release, order resumes from ptr.
- Wrap-around, SIZE=5:
  - Stimulus: only din[4], then din[0] and din[4] valid together.
  - Response: after 4 is granted, ptr=0; the next grant goes to 0, then to 4.
- Mid-stream reset:
  - Stimulus: rst asserted for 1 cycle while dout.valid=1 and dout.ready=0.
  - Response: dout.valid=0 the next cycle; ptr=0; the first grant after reset goes to the lowest-index valid input.
